// File: rtl/lfu_blit_sequencer.sv
// Drives a bytewise 4-bit logic function over a memory block: read src, read dst, write f(src,dst) to dst.
// One request per state, and each state waits for MGNT. Unneeded reads are skipped, so a fill takes 1 cycle per element.
module lfu_blit_sequencer #(
    parameter int AW = 20,
    parameter int DW = 8,
    parameter int LW = 16
) (
    input  logic          MasterClock,
    input  logic          RESETL,
    input  logic          CMD_VALID,
    output logic          CMD_READY,
    input  logic [AW-1:0] CMD_SRC,
    input  logic [AW-1:0] CMD_DST,
    input  logic [LW-1:0] CMD_LEN,
    input  logic [3:0]    CMD_LFUC,
    input  logic          ABORT,
    output logic          MREQ,
    output logic          MWR,
    output logic [AW-1:0] MADDR,
    output logic [DW-1:0] MWDATA,
    input  logic [DW-1:0] MRDATA,
    input  logic          MGNT,
    output logic          BUSY,
    output logic          DONE
);
    typedef enum logic [2:0] {IDLE, RDSRC, RDDST, WRDST, FIN} state_t;

    state_t        state;
    logic [AW-1:0] src_a;
    logic [AW-1:0] dst_a;
    logic [LW-1:0] cnt;
    logic [3:0]    lfuc;
    logic          ns_r;
    logic          nd_r;
    logic [DW-1:0] src_reg;
    logic [DW-1:0] dst_reg;
    logic          cmd_ns;
    logic          cmd_nd;

    function automatic logic [DW-1:0] lfu(input logic [3:0] c, input logic [DW-1:0] s,
                                          input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DW; i++) r[i] = c[{s[i], d[i]}];
        return r;
    endfunction

    function automatic state_t first_state(input logic ns, input logic nd);
        state_t st;
        if (ns)      st = RDSRC;
        else if (nd) st = RDDST;
        else         st = WRDST;
        return st;
    endfunction

    always_comb begin
        cmd_nd = (CMD_LFUC[1] != CMD_LFUC[0]) | (CMD_LFUC[3] != CMD_LFUC[2]);
        cmd_ns = (CMD_LFUC[2] != CMD_LFUC[0]) | (CMD_LFUC[3] != CMD_LFUC[1]);
    end

    // Bus outputs are pure decodes of state and working registers, so they hold until grant.
    assign CMD_READY = (state == IDLE);
    assign BUSY      = (state != IDLE);
    assign DONE      = (state == FIN);
    assign MREQ      = (state == RDSRC) || (state == RDDST) || (state == WRDST);
    assign MWR       = (state == WRDST);
    assign MADDR     = (state == RDSRC) ? src_a : dst_a;

    always_comb begin
        MWDATA = lfu(lfuc, ns_r ? src_reg : '0, nd_r ? dst_reg : '0);
    end

    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            state   <= IDLE;
            src_a   <= '0;
            dst_a   <= '0;
            cnt     <= '0;
            lfuc    <= '0;
            ns_r    <= 1'b0;
            nd_r    <= 1'b0;
            src_reg <= '0;
            dst_reg <= '0;
        end else if (state != IDLE && ABORT) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (CMD_VALID) begin
                        src_a <= CMD_SRC;
                        dst_a <= CMD_DST;
                        cnt   <= CMD_LEN;
                        lfuc  <= CMD_LFUC;
                        ns_r  <= cmd_ns;
                        nd_r  <= cmd_nd;
                        state <= (CMD_LEN == '0) ? FIN : first_state(cmd_ns, cmd_nd);
                    end
                end
                RDSRC: begin
                    if (MGNT) begin
                        src_reg <= MRDATA;
                        state   <= nd_r ? RDDST : WRDST;
                    end
                end
                RDDST: begin
                    if (MGNT) begin
                        dst_reg <= MRDATA;
                        state   <= WRDST;
                    end
                end
                WRDST: begin
                    if (MGNT) begin
                        src_a <= src_a + 1'b1;
                        dst_a <= dst_a + 1'b1;
                        cnt   <= cnt - 1'b1;
                        state <= (cnt == LW'(1)) ? FIN : first_state(ns_r, nd_r);
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lfu_blit_sequencer.sv
// Directed bench: byte memory model with optional two-cycle grant delay, access log, immediate-assertion checks.
module tb_lfu_blit_sequencer;
    logic        clk = 1'b0;
    logic        RESETL, CMD_VALID, CMD_READY, ABORT;
    logic [19:0] CMD_SRC, CMD_DST, MADDR;
    logic [15:0] CMD_LEN;
    logic [3:0]  CMD_LFUC;
    logic        MREQ, MWR, MGNT, BUSY, DONE;
    logic [7:0]  MWDATA, MRDATA;

    typedef struct {
        logic        wr;
        logic [19:0] addr;
        logic [7:0]  data;
        int          cyc;
    } acc_t;

    logic [7:0] mem [0:(1<<20)-1];
    acc_t       log_q[$];
    int         checks = 0, errors = 0;
    int         cyc = 0, wcnt = 0, done_cnt = 0, mreq_cycles = 0;
    bit         wait_mode = 1'b0, prev_hold = 1'b0;
    logic [19:0] p_addr;
    logic        p_wr;
    logic [7:0]  p_data;

    lfu_blit_sequencer dut (
        .MasterClock(clk), .RESETL(RESETL), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_SRC(CMD_SRC), .CMD_DST(CMD_DST), .CMD_LEN(CMD_LEN), .CMD_LFUC(CMD_LFUC),
        .ABORT(ABORT), .MREQ(MREQ), .MWR(MWR), .MADDR(MADDR), .MWDATA(MWDATA),
        .MRDATA(MRDATA), .MGNT(MGNT), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 clk = ~clk;
    assign MRDATA = mem[MADDR];

    always @(posedge clk) begin
        cyc++;
        #2;
        MGNT = wait_mode ? (MREQ && wcnt == 2) : 1'b1;
    end

    // Bus monitor: logs completed accesses, commits writes, checks request hold during wait states.
    always @(negedge clk) begin
        if (!RESETL) begin
            prev_hold = 1'b0;
            wcnt = 0;
        end else begin
            if (MREQ) begin
                mreq_cycles++;
                if (prev_hold) begin
                    checks++;
                    assert (MADDR === p_addr && MWR === p_wr && (!MWR || MWDATA === p_data)) else begin
                        errors++;
                        $error("FAIL hold_stable observed %h/%b/%h expected %h/%b/%h",
                               MADDR, MWR, MWDATA, p_addr, p_wr, p_data);
                    end
                end
                if (MGNT === 1'b1) begin
                    log_q.push_back('{MWR, MADDR, MWR ? MWDATA : MRDATA, cyc});
                    if (MWR) mem[MADDR] = MWDATA;
                    wcnt = 0;
                    prev_hold = 1'b0;
                end else begin
                    wcnt++;
                    prev_hold = 1'b1;
                end
                p_addr = MADDR;
                p_wr   = MWR;
                p_data = MWDATA;
            end else begin
                prev_hold = 1'b0;
            end
            if (DONE) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_acc(input int i, input logic wr, input logic [19:0] a, input logic [7:0] d,
                           input int c);
        acc_t e;
        if (i >= log_q.size()) begin
            chk("acc_missing", i, log_q.size());
        end else begin
            e = log_q[i];
            chk("acc_wr", e.wr, wr);
            chk("acc_addr", e.addr, a);
            chk("acc_data", e.data, d);
            chk("acc_cyc", e.cyc, c);
        end
    endtask

    task automatic issue(input logic [19:0] s, input logic [19:0] d, input logic [15:0] n,
                         input logic [3:0] c, output int acc);
        @(negedge clk);
        log_q.delete();
        CMD_SRC = s; CMD_DST = d; CMD_LEN = n; CMD_LFUC = c; CMD_VALID = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_done(output int dn);
        dn = -1;
        if (DONE) dn = cyc;
        for (int k = 0; k < 300 && dn < 0; k++) begin
            @(negedge clk);
            if (DONE) dn = cyc;
        end
        if (dn < 0) chk("done_timeout", 0, 1);
    endtask

    int a, dn, mq, dc;

    initial begin
        RESETL = 1'b0; CMD_VALID = 1'b0; ABORT = 1'b0;
        CMD_SRC = '0; CMD_DST = '0; CMD_LEN = '0; CMD_LFUC = '0;
        mem[20'h00100] = 8'h0F; mem[20'h00200] = 8'h3C;
        mem[20'h00110] = 8'h0F; mem[20'h00210] = 8'h3C;
        mem[20'h00120] = 8'hF0; mem[20'h00220] = 8'hFF;
        mem[20'h00300] = 8'hA5; mem[20'h00301] = 8'h5A;
        mem[20'hFFFFF] = 8'h77; mem[20'h00000] = 8'h77;
        for (int i = 0; i < 4; i++) begin
            mem[20'h00600 + i] = 8'h11 * (i + 1);
            mem[20'h00700 + i] = 8'h0F;
        end
        #12;
        chk("rst_mreq", MREQ, 0);
        chk("rst_mwr", MWR, 0);
        chk("rst_maddr", MADDR, 0);
        chk("rst_mwdata", MWDATA, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        @(negedge clk);
        RESETL = 1'b1;
        #1;
        chk("rst_ready", CMD_READY, 1);

        // XOR read-modify-write, zero wait
        issue(20'h00100, 20'h00200, 16'd1, 4'b0110, a);
        wait_done(dn);
        chk("xor_nacc", log_q.size(), 3);
        chk_acc(0, 1'b0, 20'h00100, 8'h0F, a);
        chk_acc(1, 1'b0, 20'h00200, 8'h3C, a + 1);
        chk_acc(2, 1'b1, 20'h00200, 8'h33, a + 2);
        chk("xor_done_cyc", dn, a + 3);
        chk("xor_ready_at_done", CMD_READY, 0);
        @(negedge clk);
        chk("xor_ready_after", CMD_READY, 1);
        chk("xor_done_width", DONE, 0);

        // Fill: writes only
        issue(20'h00000, 20'h00010, 16'd3, 4'b1111, a);
        wait_done(dn);
        chk("fill_nacc", log_q.size(), 3);
        for (int i = 0; i < 3; i++) chk_acc(i, 1'b1, 20'h00010 + i, 8'hFF, a + i);
        chk("fill_done_cyc", dn, a + 3);

        // Copy
        issue(20'h00300, 20'h00400, 16'd2, 4'b1100, a);
        wait_done(dn);
        chk("copy_nacc", log_q.size(), 4);
        chk_acc(0, 1'b0, 20'h00300, 8'hA5, a);
        chk_acc(1, 1'b1, 20'h00400, 8'hA5, a + 1);
        chk_acc(2, 1'b0, 20'h00301, 8'h5A, a + 2);
        chk_acc(3, 1'b1, 20'h00401, 8'h5A, a + 3);
        chk("copy_done_cyc", dn, a + 4);

        // Invert
        issue(20'h00300, 20'h00500, 16'd2, 4'b0011, a);
        wait_done(dn);
        chk("inv_nacc", log_q.size(), 4);
        chk_acc(1, 1'b1, 20'h00500, 8'h5A, a + 1);
        chk_acc(3, 1'b1, 20'h00501, 8'hA5, a + 3);

        // XOR with two wait cycles per access
        wait_mode = 1'b1;
        issue(20'h00110, 20'h00210, 16'd1, 4'b0110, a);
        wait_done(dn);
        chk("ws_nacc", log_q.size(), 3);
        chk_acc(0, 1'b0, 20'h00110, 8'h0F, a + 2);
        chk_acc(1, 1'b0, 20'h00210, 8'h3C, a + 5);
        chk_acc(2, 1'b1, 20'h00210, 8'h33, a + 8);
        chk("ws_done_cyc", dn, a + 9);
        chk("ws_mem", mem[20'h00210], 8'h33);
        wait_mode = 1'b0;

        // Address wrap with zero fill
        issue(20'h00000, 20'hFFFFF, 16'd2, 4'b0000, a);
        wait_done(dn);
        chk("wrap_nacc", log_q.size(), 2);
        chk_acc(0, 1'b1, 20'hFFFFF, 8'h00, a);
        chk_acc(1, 1'b1, 20'h00000, 8'h00, a + 1);
        chk("wrap_mem_top", mem[20'hFFFFF], 8'h00);
        chk("wrap_mem_zero", mem[20'h00000], 8'h00);

        // Zero length
        mq = mreq_cycles;
        issue(20'h00100, 20'h00200, 16'd0, 4'b0110, a);
        wait_done(dn);
        chk("len0_done_cyc", dn, a);
        @(negedge clk);
        chk("len0_no_mreq", mreq_cycles, mq);
        chk("len0_ready", CMD_READY, 1);

        // ABORT ignored in IDLE
        ABORT = 1'b1;
        @(negedge clk);
        ABORT = 1'b0;
        chk("abort_idle_busy", BUSY, 0);

        // Abort during RDDST of element 2 of 4
        dc = done_cnt;
        issue(20'h00600, 20'h00700, 16'd4, 4'b0110, a);
        repeat (4) @(negedge clk);
        chk("abort_pre_maddr", MADDR, 20'h00701);
        chk("abort_pre_mreq", {MREQ, MWR}, 2'b10);
        ABORT = 1'b1;
        @(negedge clk);
        ABORT = 1'b0;
        chk("abort_busy", BUSY, 0);
        chk("abort_mreq", MREQ, 0);
        mq = mreq_cycles;
        repeat (6) @(negedge clk);
        chk("abort_no_mreq", mreq_cycles, mq);
        chk("abort_no_done", done_cnt, dc);
        chk("abort_nacc", log_q.size(), 5);
        chk("abort_mem_elem1", mem[20'h00700], 8'h1E);
        chk("abort_mem_elem2", mem[20'h00701], 8'h0F);

        // Reset during a write, then a fresh command
        issue(20'h00000, 20'h00800, 16'd3, 4'b1111, a);
        @(negedge clk);
        #2;
        RESETL = 1'b0;
        #1;
        chk("arst_mreq", MREQ, 0);
        chk("arst_mwr", MWR, 0);
        chk("arst_maddr", MADDR, 0);
        chk("arst_mwdata", MWDATA, 0);
        chk("arst_busy", BUSY, 0);
        repeat (2) @(negedge clk);
        RESETL = 1'b1;
        issue(20'h00120, 20'h00220, 16'd1, 4'b0110, a);
        wait_done(dn);
        chk_acc(2, 1'b1, 20'h00220, 8'h0F, a + 2);
        chk("post_rst_done_cyc", dn, a + 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
